// File: rtl/transpose_buffer.sv
// transpose_buffer: streaming ELEMS x ELEMS tile transposer with ping-pong
// banks. One bank fills from the input stream while the other drains to the
// output register, so tiles flow at full rate unless downstream stalls.
module transpose_buffer #(
  parameter int DATA_SIZE = 8,
  parameter int ELEMS     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_SIZE*ELEMS-1:0] in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic                       in_bypass,
  output logic [DATA_SIZE*ELEMS-1:0] out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy
);

  localparam int WROW_W = $clog2(ELEMS + 1);
  localparam int RCOL_W = $clog2(ELEMS);
  localparam logic [WROW_W-1:0] LAST_ROW = WROW_W'(ELEMS - 1);
  localparam logic [RCOL_W-1:0] LAST_COL = RCOL_W'(ELEMS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_st_t;

  // Bank storage and per-bank flags (contents survive reset by design)
  bank_st_t             r_state     [2];
  bank_st_t             w_state_nxt [2];
  logic [DATA_SIZE-1:0] r_mem       [2][ELEMS][ELEMS];
  logic                 r_mode      [2];
  logic                 r_last      [2];

  // Write / read pointers
  logic              r_wbank;
  logic [WROW_W-1:0] r_wrow;
  logic              r_rbank;
  logic [RCOL_W-1:0] r_rcol;

  // Output register stage
  logic [DATA_SIZE*ELEMS-1:0] r_out_p0;
  logic                       r_vld_p0;
  logic                       r_last_p0;

  logic                       w_wr;
  logic                       w_close;
  logic                       w_load;
  logic                       w_final;
  logic [DATA_SIZE*ELEMS-1:0] w_col;

  assign in_ready = !rst && ((r_state[r_wbank] == ST_EMPTY) ||
                             (r_state[r_wbank] == ST_FILLING));
  assign w_wr     = in_valid && in_ready;
  assign w_close  = w_wr && ((r_wrow == LAST_ROW) || in_last);
  assign w_load   = (r_state[r_rbank] == ST_FULL) && (!r_vld_p0 || out_ready);
  assign w_final  = w_load && (r_rcol == LAST_COL);

  assign out       = r_out_p0;
  assign out_valid = r_vld_p0;
  assign out_last  = r_last_p0;
  assign busy      = (r_state[0] != ST_EMPTY) || (r_state[1] != ST_EMPTY) || r_vld_p0;

  // Bank next-state: write side fills/closes, read side frees on final beat.
  // A bank cannot be written and drained in the same cycle (FILLING vs FULL).
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_wr && (r_wbank == 1'(b))) begin
        w_state_nxt[b] = w_close ? ST_FULL : ST_FILLING;
      end
      if (w_final && (r_rbank == 1'(b))) begin
        w_state_nxt[b] = ST_EMPTY;
      end
    end
  end

  // Bank state registers
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        r_state[b] <= ST_EMPTY;
      end else begin
        r_state[b] <= w_state_nxt[b];
      end
    end
  end

  // Write pointer: advance row per beat, flip bank when a tile closes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank <= 1'b0;
      r_wrow  <= '0;
    end else if (w_wr) begin
      if (w_close) begin
        r_wbank <= ~r_wbank;
        r_wrow  <= '0;
      end else begin
        r_wrow  <= r_wrow + WROW_W'(1);
      end
    end
  end

  // Tile flags: mode latched on the first beat, last flag on the closing beat
  always_ff @(posedge clk) begin
    if (w_wr && (r_wrow == '0)) begin
      r_mode[r_wbank] <= in_bypass;
    end
    if (w_close) begin
      r_last[r_wbank] <= in_last;
    end
  end

  // Tile storage: current row takes the beat; on close, later rows zero-pad
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int k = 0; k < ELEMS; k++) begin
        for (int j = 0; j < ELEMS; j++) begin
          if (int'(r_wrow) == k) begin
            r_mem[r_wbank][k][j] <= in[DATA_SIZE*j +: DATA_SIZE];
          end else if (w_close && (k > int'(r_wrow))) begin
            r_mem[r_wbank][k][j] <= '0;
          end
        end
      end
    end
  end

  // Column select: column rcol in transpose mode, row rcol in bypass mode
  always_comb begin
    w_col = '0;
    for (int r = 0; r < ELEMS; r++) begin
      for (int c = 0; c < ELEMS; c++) begin
        if (int'(r_rcol) == c) begin
          w_col[DATA_SIZE*r +: DATA_SIZE] = r_mode[r_rbank] ? r_mem[r_rbank][c][r]
                                                            : r_mem[r_rbank][r][c];
        end
      end
    end
  end

  // Read pointer: step column per load, flip bank after the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbank <= 1'b0;
      r_rcol  <= '0;
    end else if (w_load) begin
      if (w_final) begin
        r_rbank <= ~r_rbank;
        r_rcol  <= '0;
      end else begin
        r_rcol  <= r_rcol + RCOL_W'(1);
      end
    end
  end

  // Output register: load a new beat, or drop valid once the beat is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p0  <= '0;
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
    end else if (w_load) begin
      r_out_p0  <= w_col;
      r_vld_p0  <= 1'b1;
      r_last_p0 <= r_last[r_rbank] && (r_rcol == LAST_COL);
    end else if (r_vld_p0 && out_ready) begin
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
    end
  end

endmodule

// File: doc/transpose_buffer.md
# transpose_buffer

Streaming square-tile transposer with ping-pong storage and valid/ready handshakes on both sides. Accepts ELEMS-lane beats, assembles ELEMS-beat tiles, and emits each tile transposed or unchanged (per-tile mode) while the next tile fills. Successor to the single-buffer transpose stage in the FHE interconnect datapath, which had no backpressure. Adds:
- Continuous full-rate throughput.
- Downstream stall support.
- Early tile close on in_last, with zero padding.

## Interface
- DATA_SIZE, default FSIZE: bits per lane word.
- ELEMS, default E: lanes per beat and beats per tile (tile is ELEMS x ELEMS words, ELEMS >= 2).
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: reset, synchronous and active-high.
- in, in, DATA_SIZE*ELEMS: input beat; lane j at bits [DATA_SIZE*j +: DATA_SIZE].
- in_valid, in, 1: input beat present.
- in_ready, out, 1: block can accept a beat; transfer when in_valid && in_ready.
- in_last, in, 1: closes the current tile at this beat; tile is marked last.
- in_bypass, in, 1: sampled on the first beat of a tile; 1 = pass tile unchanged, 0 = transpose.
- out, out, DATA_SIZE*ELEMS: output beat, same lane packing as in.
- out_valid, out, 1: output beat present.
- out_ready, in, 1: downstream accepts; transfer when out_valid && out_ready.
- out_last, out, 1: high on beat ELEMS-1 of a tile marked last.
- busy, out, 1: any bank not EMPTY, or out_valid high.

## Operation
- Storage: two banks, B0 and B1, each ELEMS x ELEMS words plus mode and last flags. Bank states: EMPTY -> FILLING -> FULL -> EMPTY.
- Write side:
  - Pointer wbank (reset B0) and row counter wrow (width $clog2(ELEMS+1), reset 0).
  - in_ready = !rst && bank[wbank] is EMPTY or FILLING.
  - Accepted beat with wrow = k: store M[k][j] = lane j. On k = 0, bank goes FILLING and mode is latched from in_bypass.
  - Close condition: wrow = ELEMS-1, or in_last on the accepted beat.
  - On close: rows k+1..ELEMS-1 are written as zero, last flag = in_last, bank goes FULL, wrow goes 0, wbank toggles.
  - in_last on the first beat of a tile gives one data row and ELEMS-1 zero rows.
- Read side:
  - Pointer rbank (reset B0) and column counter rcol (reset 0).
  - out, out_valid and out_last are registers.
  - Load condition: bank[rbank] is FULL && (!out_valid || out_ready).
  - On load, out lane r is loaded with M[r][rcol] in transpose mode, or M[rcol][r] in bypass mode. out_valid goes to 1, out_last = last flag && rcol = ELEMS-1, and rcol increments.
  - On load with rcol = ELEMS-1: bank goes EMPTY in that same edge, rcol goes 0, rbank toggles.
  - If out_valid && out_ready and no load: out_valid goes 0 and out_last goes 0.
- Every tile, whether full or closed early, produces exactly ELEMS output beats, in acceptance order.
- Banks alternate strictly, so input order equals output order.

## Timing
- Reset, synchronous active-high, takes effect at the edge where rst = 1:
  - wrow, rcol, wbank and rbank go to 0; both banks go EMPTY.
  - out_valid, out_last and out go to 0.
  - in_ready is 0 while rst = 1; busy is 0 on the cycle after reset.
  - Bank contents are not cleared.
- Reset mid-tile discards all partial and full tiles; no out_valid appears until a new tile closes.
- Latency: closing beat accepted at edge t means the bank is FULL from t. The first output beat is loaded at edge t+1 (out_valid high in cycle t+1) if out_ready permits.
- Throughput: with out_ready held 1 and in_valid held 1, in_ready stays 1 and out_valid stays 1 after the first tile, with zero bubbles.
  - This holds because a bank is freed when its final beat loads, and is writable the next cycle.
- Both banks FULL (downstream stalled): in_ready = 0 until a bank's final beat loads.
- Stall: while out_valid && !out_ready, out, out_valid and out_last hold stable.
- Simultaneous write-close into one bank and final-beat-load from the other in the same edge is legal. Each bank updates independently.
- in_last, in_bypass and in are ignored when in_valid && in_ready is false.

## Test plan
- ELEMS=4, DATA_SIZE=8, transpose, out_ready=1. Input beats row k lane j = 16k+j (k = 0..3). Required output beat c lane r = 16r+c, so beat 0 = {0x30,0x20,0x10,0x00} MSB-first; first out_valid 1 cycle after the 4th input beat; out_last=0.
- Same stimulus with in_bypass=1 on beat 0 (then 0 on later beats). Output beats equal input beats exactly; mode must not change mid-tile.
- Continuous 8 tiles with in_valid=1 and out_ready=1. in_ready never drops after reset; 32 output beats with no gap; data matches the transpose of each tile.
- Downstream stall: out_ready=0 while feeding 3 tiles.
  - in_ready drops after the 8th accepted beat (both banks FULL).
  - out holds beat 0 of tile 0 stable.
  - After out_ready=1, all 12 beats arrive in order, and in_ready rises one cycle after tile 0's final beat loads.
- Early close: 2 beats {1,2,3,4} and {5,6,7,8} (lane 0 first), in_last on the 2nd. Output lanes 0..3 are:
  - beat 0: {1,5,0,0}
  - beat 1: {2,6,0,0}
  - beat 2: {3,7,0,0}
  - beat 3: {4,8,0,0}, with out_last=1 on beat 3 only.
- Reset mid-operation: assert rst for 1 cycle after 2 beats of tile 1, with tile 0 half drained.
  - Next cycle: out_valid=0, out_last=0, out=0, busy=0.
  - Then one fresh tile transposes correctly from beat 0.
